// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with per-pin direction, atomic set/clear
// aliases, synchronised and debounced inputs, and sticky edge interrupts.
module gpio_bank #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      address_in,
  input  logic             sel_in,
  input  logic             read_in,
  output logic [31:0]      read_value_out,
  input  logic [3:0]       write_mask_in,
  input  logic [31:0]      write_value_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_out
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_DIR     = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_OUT_SET = 3'd6,
    REG_OUT_CLR = 3'd7
  } regSel_e;

  regSel_e          w_reg;
  logic [31:0]      w_laneMask;
  logic [31:0]      w_wdata;
  logic [WIDTH-1:0] w_wbits;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_outNext;
  logic [WIDTH-1:0] w_filtNext;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_statusNext;
  logic [WIDTH-1:0] w_rdata;
  logic [CW-1:0]    w_cntNext [WIDTH];
  logic             w_unused;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_riseEn;
  logic [WIDTH-1:0] r_fallEn;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_filt;
  logic [CW-1:0]    r_cnt [WIDTH];

  assign w_reg      = regSel_e'(address_in[4:2]);
  assign w_laneMask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                       {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign w_wdata    = write_value_in & w_laneMask;
  assign w_wbits    = w_wdata[WIDTH-1:0];
  assign w_wmask    = w_laneMask[WIDTH-1:0];
  assign w_unused   = ^{read_in, address_in[31:5], address_in[1:0], w_wdata, w_laneMask};

  always_comb begin
    w_outNext = r_out;
    if (sel_in) begin
      case (w_reg)
        REG_OUT:     w_outNext = (r_out & ~w_wmask) | w_wbits;
        REG_OUT_SET: w_outNext = r_out | w_wbits;
        REG_OUT_CLR: w_outNext = r_out & ~w_wbits;
        default:     w_outNext = r_out;
      endcase
    end
  end

  // A pin is accepted only after it has disagreed with filt for DEBOUNCE straight cycles.
  always_comb begin
    w_filtNext = r_filt;
    for (int i = 0; i < WIDTH; i++) begin
      w_cntNext[i] = '0;
      if (r_s2[i] != r_filt[i]) begin
        if (r_cnt[i] == CMAX) begin
          w_filtNext[i] = r_s2[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise       = ~r_filt & w_filtNext;
  assign w_fall       = r_filt & ~w_filtNext;
  assign w_clear      = (sel_in && w_reg == REG_STATUS) ? w_wbits : '0;
  assign w_statusNext = (r_status & ~w_clear) | (w_rise & r_riseEn) | (w_fall & r_fallEn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_riseEn <= '0;
      r_fallEn <= '0;
      r_status <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_filt   <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_out    <= w_outNext;
      r_status <= w_statusNext;
      r_s1     <= gpio_in;
      r_s2     <= r_s1;
      r_filt   <= w_filtNext;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cntNext[i];
      if (sel_in && w_reg == REG_DIR)     r_dir    <= (r_dir & ~w_wmask) | w_wbits;
      if (sel_in && w_reg == REG_RISE_EN) r_riseEn <= (r_riseEn & ~w_wmask) | w_wbits;
      if (sel_in && w_reg == REG_FALL_EN) r_fallEn <= (r_fallEn & ~w_wmask) | w_wbits;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_OUT:     w_rdata = r_out;
      REG_DIR:     w_rdata = r_dir;
      REG_IN:      w_rdata = r_filt;
      REG_RISE_EN: w_rdata = r_riseEn;
      REG_FALL_EN: w_rdata = r_fallEn;
      REG_STATUS:  w_rdata = r_status;
      default:     w_rdata = '0;
    endcase
  end

  assign read_value_out = sel_in ? 32'(w_rdata) : 32'd0;
  assign ready_out      = sel_in;
  assign gpio_out       = r_out;
  assign gpio_oe        = r_dir;
  assign irq_out        = |r_status;

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised, memory-mapped general-purpose I/O bank on the shared SoC memory bus. Replaces the fixed-width ad-hoc LED/button/PMOD/Arduino registers in the top level with one instantiable block.
- Each pin has:
  - a direction bit;
  - an output register with atomic set/clear aliases;
  - a synchroniser and debounce filter on the input;
  - rising/falling edge detection feeding a sticky, write-1-to-clear interrupt status and a level interrupt output.

Parameters:
- WIDTH, 8, number of pins (1..32); register bits above WIDTH read 0, writes ignored
- DEBOUNCE, 1, consecutive cycles a synchronised input must differ from the filtered value before it is accepted (1..65535; 1 = no filtering)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address_in  in  32  bus address; only [4:2] decoded
- sel_in  in  1  block select from top-level decoder
- read_in  in  1  read strobe; no read side effects, reserved
- read_value_out  out  32  read data; all zero when sel_in=0, so it can be ORed into the bus
- write_mask_in  in  4  byte-lane write enables
- write_value_in  in  32  write data
- ready_out  out  1  equals sel_in, combinational; single-cycle access
- gpio_in  in  WIDTH  asynchronous pin inputs
- gpio_out  out  WIDTH  output values (= OUT register)
- gpio_oe  out  WIDTH  output enables (= DIR register, 1 = drive)
- irq_out  out  1  OR of all IRQ_STATUS bits

Behaviour:
- Reset (asynchronous, active-high): every register, synchroniser, filter, counter and output clears to 0. gpio_out=0, gpio_oe=0, irq_out=0.
- Register map, offset from address[4:2]:
  - 0x00 OUT (rw)
  - 0x04 DIR (rw)
  - 0x08 IN (ro, filtered input)
  - 0x0C RISE_EN (rw)
  - 0x10 FALL_EN (rw)
  - 0x14 IRQ_STATUS (rw1c)
  - 0x18 OUT_SET (wo, reads 0)
  - 0x1C OUT_CLR (wo, reads 0)
- Writes:
  - Take effect at the clk edge where sel_in=1.
  - Each byte lane i is applied only if write_mask_in[i]=1.
  - OUT_SET ORs the masked data into OUT; OUT_CLR ANDs the inverse of the masked data into OUT.
  - Writes to IN are ignored.
- Reads: combinational from current register state; same-cycle ready.
- Input path, per bit:
  - Two-flop synchroniser (s1, s2).
  - Per-bit counter, width clog2(DEBOUNCE+1):
    - s2 == filt: counter <= 0.
    - s2 != filt and counter == DEBOUNCE-1: filt <= s2, counter <= 0.
    - Otherwise: counter increments.
  - A glitch shorter than DEBOUNCE cycles never reaches filt.
  - Latency: a pin level first sampled at edge k appears in IN at edge k+1+DEBOUNCE.
- Edge detect, at the edge where filt updates:
  - rise = ~filt & filt_next
  - fall = filt & ~filt_next
- IRQ_STATUS update: status <= (status & ~clear) | (rise & RISE_EN) | (fall & FALL_EN).
  - clear = byte-masked write data to 0x14.
  - An edge and a clear of the same bit in the same cycle: set wins.
- irq_out: registered status ORed. Asserts in the same cycle IN changes; stays high until software clears every set bit.
- Disabling RISE_EN/FALL_EN does not clear already-set status bits.
- Pins driven high at reset release yield a filtered rising edge. No status results unless RISE_EN was written before the edge.
- DIR does not affect the input path; output pins still loop back through gpio_in.
- Width rules: all internal registers are WIDTH bits; read value is zero-extended to 32.

Test Plan:
- Write-mask checks (WIDTH=8):
  - Write 0x000000A5 to 0x00 with mask 4'b0001 -> gpio_out=0xA5, read 0x00 = 0x000000A5.
  - Write 0xFFFFFF00 with mask 4'b1110 -> OUT unchanged 0xA5.
- Set/clear aliases: OUT=0x0F, write 0xF0 to 0x18 -> OUT=0xFF; write 0x81 to 0x1C -> OUT=0x7E; reads of 0x18 and 0x1C return 0.
- Debounce filtering (DEBOUNCE=4):
  - Raise gpio_in[3] for 3 cycles, then drop -> IN stays 0x00, IRQ_STATUS stays 0.
  - Hold it high -> IN[3]=1 exactly 5 edges after first sampling.
- Rising-edge interrupt: RISE_EN=0x08, IN[3] rises -> IRQ_STATUS=0x08 and irq_out=1 in the same cycle; write 0x08 to 0x14 -> status 0, irq_out 0.
- Collision and select: a new falling edge with FALL_EN=0x01 in the same cycle as a clear of bit 0 -> bit 0 remains 1. With sel_in=0 -> read_value_out=0 and ready_out=0.
- Mid-operation reset: assert reset while counters are mid-count and IRQ_STATUS=0xFF -> all outputs 0 immediately, without waiting for a clk edge; after release, IN tracks pins after 1+DEBOUNCE edges.
